// File: rtl/rbi_ring_arb_if.sv
// Ring arbiter bus bundle: two request ports, ring slot in/out,
// response strobes and drain control.
interface rbi_ring_arb_if;
  logic [7:0]   unitNodeId;

  logic         reqValidA;
  logic         reqReadyA;
  logic [6:0]   reqSeqA;
  logic [15:0]  reqOpmA;
  logic [47:0]  reqAddrA;
  logic [127:0] reqDataA;

  logic         reqValidB;
  logic         reqReadyB;
  logic [6:0]   reqSeqB;
  logic [15:0]  reqOpmB;
  logic [47:0]  reqAddrB;
  logic [127:0] reqDataB;

  logic [15:0]  memSeqIn;
  logic [15:0]  memOpmIn;
  logic [47:0]  memAddrIn;
  logic [127:0] memDataIn;

  logic [15:0]  memSeqOut;
  logic [15:0]  memOpmOut;
  logic [47:0]  memAddrOut;
  logic [127:0] memDataOut;

  logic         respValidA;
  logic         respValidB;
  logic         drainReq;
  logic         drained;
  logic         errStray;

  modport slave (
    input  unitNodeId,
    input  reqValidA, reqSeqA, reqOpmA, reqAddrA, reqDataA,
    output reqReadyA,
    input  reqValidB, reqSeqB, reqOpmB, reqAddrB, reqDataB,
    output reqReadyB,
    input  memSeqIn, memOpmIn, memAddrIn, memDataIn,
    output memSeqOut, memOpmOut, memAddrOut, memDataOut,
    output respValidA, respValidB,
    input  drainReq,
    output drained, errStray
  );

  modport master (
    output unitNodeId,
    output reqValidA, reqSeqA, reqOpmA, reqAddrA, reqDataA,
    input  reqReadyA,
    output reqValidB, reqSeqB, reqOpmB, reqAddrB, reqDataB,
    input  reqReadyB,
    output memSeqIn, memOpmIn, memAddrIn, memDataIn,
    input  memSeqOut, memOpmOut, memAddrOut, memDataOut,
    input  respValidA, respValidB,
    output drainReq,
    input  drained, errStray
  );
endinterface

// File: rtl/rbi_ring_arb.sv
// Two-port ring bus injector: consumes own responses, forwards
// foreign slots, round-robin injects requests into free slots.
module rbi_ring_arb (
  input  logic          clock,
  input  logic          reset,
  rbi_ring_arb_if.slave bus
);

  localparam logic [15:0] JX2_RBI_OPM_IDLE = 16'h0000;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    QUIET
  } state_t;

  state_t     state;
  logic [2:0] countA;
  logic [2:0] countB;
  logic [2:0] nextCountA;
  logic [2:0] nextCountB;
  logic       rrPtr;
  logic       isResp;
  logic       slotFree;
  logic       respA;
  logic       respB;
  logic       eligA;
  logic       eligB;
  logic       grantA;
  logic       grantB;

  // Slot classification, arbitration and counter next-state.
  always_comb begin
    isResp   = (bus.memOpmIn[7:6] == 2'b01) &&
               (bus.memSeqIn[15:8] == bus.unitNodeId);
    slotFree = (bus.memOpmIn[7:0] == JX2_RBI_OPM_IDLE[7:0]) || isResp;
    respA    = !reset && isResp && !bus.memSeqIn[7];
    respB    = !reset && isResp && bus.memSeqIn[7];
    eligA    = !reset && bus.reqValidA && (countA < 3'd4) &&
               (state == RUN) && slotFree;
    eligB    = !reset && bus.reqValidB && (countB < 3'd4) &&
               (state == RUN) && slotFree;
    grantA   = eligA && (!eligB || !rrPtr);
    grantB   = eligB && (!eligA || rrPtr);

    nextCountA = countA;
    if (grantA && !respA)
      nextCountA = countA + 3'd1;
    else if (respA && !grantA && countA != 3'd0)
      nextCountA = countA - 3'd1;

    nextCountB = countB;
    if (grantB && !respB)
      nextCountB = countB + 3'd1;
    else if (respB && !grantB && countB != 3'd0)
      nextCountB = countB - 3'd1;
  end

  assign bus.reqReadyA  = grantA;
  assign bus.reqReadyB  = grantB;
  assign bus.respValidA = respA;
  assign bus.respValidB = respB;
  assign bus.errStray   = (respA && countA == 3'd0) ||
                          (respB && countB == 3'd0);
  assign bus.drained    = (state == QUIET);

  // Drain FSM; QUIET is judged on post-update counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN:
          if (bus.drainReq) state <= DRAIN;
        DRAIN:
          if (!bus.drainReq)
            state <= RUN;
          else if (nextCountA == 3'd0 && nextCountB == 3'd0)
            state <= QUIET;
        QUIET:
          if (!bus.drainReq) state <= RUN;
        default:
          state <= RUN;
      endcase
    end
  end

  // Outstanding counters, round-robin pointer and ring out slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      countA         <= 3'd0;
      countB         <= 3'd0;
      rrPtr          <= 1'b0;
      bus.memSeqOut  <= 16'h0;
      bus.memOpmOut  <= JX2_RBI_OPM_IDLE;
      bus.memAddrOut <= 48'h0;
      bus.memDataOut <= 128'h0;
    end else begin
      countA <= nextCountA;
      countB <= nextCountB;
      if (grantA)
        rrPtr <= 1'b1;
      else if (grantB)
        rrPtr <= 1'b0;

      if (!slotFree) begin
        bus.memSeqOut  <= bus.memSeqIn;
        bus.memOpmOut  <= bus.memOpmIn;
        bus.memAddrOut <= bus.memAddrIn;
        bus.memDataOut <= bus.memDataIn;
      end else if (grantA) begin
        bus.memSeqOut  <= {bus.unitNodeId, 1'b0, bus.reqSeqA};
        bus.memOpmOut  <= bus.reqOpmA;
        bus.memAddrOut <= bus.reqAddrA;
        bus.memDataOut <= bus.reqDataA;
      end else if (grantB) begin
        bus.memSeqOut  <= {bus.unitNodeId, 1'b1, bus.reqSeqB};
        bus.memOpmOut  <= bus.reqOpmB;
        bus.memAddrOut <= bus.reqAddrB;
        bus.memDataOut <= bus.reqDataB;
      end else begin
        bus.memSeqOut  <= 16'h0;
        bus.memOpmOut  <= JX2_RBI_OPM_IDLE;
        bus.memAddrOut <= 48'h0;
        bus.memDataOut <= 128'h0;
      end
    end
  end

endmodule

// File: tb/tb_rbi_ring_arb.sv
// Directed bench for rbi_ring_arb: strobes checked mid-cycle,
// expected ring slots queued and compared after the clock edge.
module tb_rbi_ring_arb;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  logic [207:0] expQ[$];

  rbi_ring_arb_if bus();

  rbi_ring_arb dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(string tag, logic [207:0] obs, logic [207:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ringIdle();
    bus.memSeqIn  = 16'h0;
    bus.memOpmIn  = 16'h0;
    bus.memAddrIn = 48'h0;
    bus.memDataIn = 128'h0;
  endtask

  task automatic ringSlot(logic [15:0] seq, logic [15:0] opm);
    bus.memSeqIn  = seq;
    bus.memOpmIn  = opm;
    bus.memAddrIn = 48'hABCD_EF01_2345;
    bus.memDataIn = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  endtask

  task automatic setReq(logic vA, logic vB);
    bus.reqValidA = vA;
    bus.reqValidB = vB;
  endtask

  // One clock: strobes checked at negedge, slot checked after posedge.
  task automatic step(string tag, bit rdyA, bit rdyB, bit rA, bit rB,
                      bit stray, bit drn, bit fwd);
    logic [207:0] exp;
    logic [207:0] got;
    @(negedge clock);
    check({tag, ".readyA"}, 208'(bus.reqReadyA), 208'(rdyA));
    check({tag, ".readyB"}, 208'(bus.reqReadyB), 208'(rdyB));
    check({tag, ".respA"},  208'(bus.respValidA), 208'(rA));
    check({tag, ".respB"},  208'(bus.respValidB), 208'(rB));
    check({tag, ".stray"},  208'(bus.errStray), 208'(stray));
    check({tag, ".drained"}, 208'(bus.drained), 208'(drn));
    if (fwd)
      exp = {bus.memSeqIn, bus.memOpmIn, bus.memAddrIn, bus.memDataIn};
    else if (rdyA)
      exp = {bus.unitNodeId, 1'b0, bus.reqSeqA, bus.reqOpmA,
             bus.reqAddrA, bus.reqDataA};
    else if (rdyB)
      exp = {bus.unitNodeId, 1'b1, bus.reqSeqB, bus.reqOpmB,
             bus.reqAddrB, bus.reqDataB};
    else
      exp = 208'h0;
    expQ.push_back(exp);
    @(posedge clock);
    #1;
    got = {bus.memSeqOut, bus.memOpmOut, bus.memAddrOut, bus.memDataOut};
    check({tag, ".slot"}, got, expQ.pop_front());
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.unitNodeId = 8'h12;
    bus.drainReq   = 1'b0;
    bus.reqSeqA  = 7'h05;
    bus.reqOpmA  = 16'h1111;
    bus.reqAddrA = 48'h0000_AAAA_0001;
    bus.reqDataA = 128'hA5A5_0000_0000_0000_0000_0000_0000_0001;
    bus.reqSeqB  = 7'h0A;
    bus.reqOpmB  = 16'h2222;
    bus.reqAddrB = 48'h0000_BBBB_0002;
    bus.reqDataB = 128'h5A5A_0000_0000_0000_0000_0000_0000_0002;
    setReq(1'b0, 1'b0);
    ringIdle();
    @(posedge clock);
    #1;

    setReq(1'b1, 1'b1);
    ringSlot(16'h1205, 16'h0040);
    step("rst", 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b0;
    ringIdle();
    step("rrA0", 1, 0, 0, 0, 0, 0, 0);
    step("rrB0", 0, 1, 0, 0, 0, 0, 0);
    step("rrA1", 1, 0, 0, 0, 0, 0, 0);
    step("rrB1", 0, 1, 0, 0, 0, 0, 0);

    setReq(1'b1, 1'b0);
    step("capA3", 1, 0, 0, 0, 0, 0, 0);
    step("capA4", 1, 0, 0, 0, 0, 0, 0);
    setReq(1'b1, 1'b1);
    step("capB", 0, 1, 0, 0, 0, 0, 0);

    setReq(1'b1, 1'b0);
    ringSlot(16'h1203, 16'h0040);
    step("respAfull", 0, 0, 1, 0, 0, 0, 0);
    ringSlot(16'h1285, 16'h0041);
    step("respBreuse", 1, 0, 0, 1, 0, 0, 0);

    setReq(1'b1, 1'b1);
    ringSlot(16'h3401, 16'h0123);
    step("fwd", 0, 0, 0, 0, 0, 0, 1);
    ringSlot(16'h3482, 16'h0040);
    step("fwdResp", 0, 0, 0, 0, 0, 0, 1);

    setReq(1'b0, 1'b0);
    ringSlot(16'h1285, 16'h0040);
    step("respB1", 0, 0, 0, 1, 0, 0, 0);
    step("respB0", 0, 0, 0, 1, 0, 0, 0);
    ringSlot(16'h1200, 16'h0040);
    step("respA3", 0, 0, 1, 0, 0, 0, 0);
    step("respA2", 0, 0, 1, 0, 0, 0, 0);

    ringIdle();
    bus.drainReq = 1'b1;
    step("drainEnter", 0, 0, 0, 0, 0, 0, 0);
    setReq(1'b1, 1'b0);
    step("drainHold", 0, 0, 0, 0, 0, 0, 0);
    ringSlot(16'h1200, 16'h0040);
    step("drainRespA1", 0, 0, 1, 0, 0, 0, 0);
    step("drainRespA0", 0, 0, 1, 0, 0, 0, 0);
    ringIdle();
    step("quiet", 0, 0, 0, 0, 0, 1, 0);
    ringSlot(16'h1281, 16'h0040);
    step("strayB", 0, 0, 0, 1, 1, 1, 0);
    ringIdle();
    bus.drainReq = 1'b0;
    step("quietExit", 0, 0, 0, 0, 0, 1, 0);
    step("resume", 1, 0, 0, 0, 0, 0, 0);

    setReq(1'b0, 1'b0);
    ringSlot(16'h1200, 16'h0040);
    step("respResume", 0, 0, 1, 0, 0, 0, 0);
    ringIdle();
    bus.drainReq = 1'b1;
    step("drain0Enter", 0, 0, 0, 0, 0, 0, 0);
    step("drain0", 0, 0, 0, 0, 0, 0, 0);
    step("drain0Quiet", 0, 0, 0, 0, 0, 1, 0);
    bus.drainReq = 1'b0;
    step("drain0Exit", 0, 0, 0, 0, 0, 1, 0);
    setReq(1'b1, 1'b0);
    step("grantA1", 1, 0, 0, 0, 0, 0, 0);

    ringSlot(16'h1200, 16'h0040);
    step("sameGrantResp", 1, 0, 1, 0, 0, 0, 0);
    setReq(1'b0, 1'b0);
    step("respLast", 0, 0, 1, 0, 0, 0, 0);
    step("respStrayA", 0, 0, 1, 0, 1, 0, 0);

    ringIdle();
    setReq(1'b1, 1'b0);
    step("preReset", 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    setReq(1'b0, 1'b0);
    step("midReset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    ringSlot(16'h1200, 16'h0040);
    step("postResetStray", 0, 0, 1, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rbi_ring_arb.md
RBI_RING_ARB -- requirements
Module: rbi_ring_arb

Interface
REQ-001 Clock and reset: one clock, `clock`; `reset` is synchronous and active-high.
REQ-002 `clock`  in  1  rising-edge clock for all state.
REQ-003 `reset`  in  1  synchronous, active-high reset.
REQ-004 `unitNodeId`  in  8  node ID stamped into seq[15:8] of every injected request.
REQ-005 `reqValidA`/`reqValidB`  in  1  port A/B request pending; held until accepted.
REQ-006 `reqReadyA`/`reqReadyB`  out  1  combinational accept strobe; transfer occurs on a cycle with valid=ready=1.
REQ-007 `reqSeqA`/`reqSeqB`  in  7  requester tag, placed in seq[6:0].
REQ-008 `reqOpmA`/`reqOpmB`  in  16  request opm (addr 48, data 128 alongside: `reqAddrX`, `reqDataX`).
REQ-009 `memSeqIn`/`memOpmIn`/`memAddrIn`/`memDataIn`  in  16/16/48/128  upstream ring slot.
REQ-010 `memSeqOut`/`memOpmOut`/`memAddrOut`/`memDataOut`  out  16/16/48/128  registered downstream ring slot.
REQ-011 `respValidA`/`respValidB`  out  1  one-cycle pulse: ring slot carries a response for that port.
REQ-012 `drainReq`  in  1  level; stop granting and wait for outstanding responses.
REQ-013 `drained`  out  1  high in the QUIET state.
REQ-014 `errStray`  out  1  one-cycle pulse on a response for a port with zero outstanding requests.

Function
REQ-015 Response detect: memOpmIn[7:6]==2'b01 and memSeqIn[15:8]==unitNodeId; port select = memSeqIn[7] (0=A, 1=B).
REQ-016 Response handling: the response pulses respValidX combinationally in the same cycle, qualified by memSeqIn[7].
REQ-017 The response slot is consumed: it is not forwarded.
REQ-018 Slot free: memOpmIn[7:0]==JX2_RBI_OPM_IDLE, or the slot is a response to this node.
REQ-019 Occupied slot: when the slot is not free, it is forwarded unchanged to the out registers, 1-cycle latency.
REQ-020 No ready is asserted on a cycle with an occupied slot.
REQ-021 Grant eligibility: reqValidX=1, outstanding countX<4, state RUN, slot free.
REQ-022 Arbitration: when both ports are eligible, round-robin pointer selects; the pointer moves to the other port after each grant.
REQ-023 Single eligible: when only one port is eligible, it is granted and the pointer points to the other port afterwards.
REQ-024 Injection, ring fields: seq out={unitNodeId, port bit, reqSeqX}; opm/addr/data from the granted port, registered on the grant edge.
REQ-025 Injection, handshake: exactly one reqReady is asserted.
REQ-026 Free slot with no grant: out registers load seq=0, opm=JX2_RBI_OPM_IDLE, addr=0, data=0.
REQ-027 Outstanding counters: 3-bit per port; +1 on grant, -1 on response.
REQ-028 Simultaneous grant and response on the same port: counter unchanged.
REQ-029 Response with count==0: counter stays 0 and errStray pulses for one cycle; respValid still pulses.
REQ-030 FSM states: RUN, DRAIN, QUIET.
REQ-031 FSM transitions:
- RUN->DRAIN when drainReq=1.
- DRAIN->QUIET when both counters==0, evaluated after that cycle's updates.
- DRAIN or QUIET->RUN when drainReq=0.
REQ-032 DRAIN and QUIET: no grants; forwarding and response pulsing continue.
REQ-033 Drain with no outstanding requests: drainReq rising with both counts already 0 reaches QUIET one cycle after DRAIN.

Reset
REQ-034 On reset, the out registers load seq=0, opm=JX2_RBI_OPM_IDLE, addr=0, data=0.
REQ-035 On reset, counters=0, RR pointer=A, and state=RUN.
REQ-036 While reset=1, reqReadyX, respValidX and errStray are 0.
REQ-037 Reset mid-transaction discards outstanding counts; later responses for pre-reset requests raise errStray.

Verification
REQ-038 Idle ring, reqValidA=1, reqSeqA=7'h05, unitNodeId=8'h12 -> reqReadyA=1 same cycle; next cycle memSeqOut=16'h1205, countA=1.
REQ-039 Both valid on 4 consecutive idle slots -> grants A,B,A,B; memSeqOut[7] sequence 0,1,0,1.
REQ-040 Port A fires 4 grants with no responses -> 5th cycle reqReadyA=0 while B is still granted.
REQ-041 Response with memOpmIn[7:6]=01, seq=16'h1285 -> respValidB=1 and countB decrements.
REQ-042 The same slot is reused for pending A, whose memSeqOut lands next cycle.
REQ-043 Foreign slot (seq[15:8]=8'h34, opm non-idle) -> forwarded bit-exact one cycle later; no ready.
REQ-044 drainReq=1 with countA=2 -> no grants, drained=0; after 2 A responses, drained=1 next cycle.
REQ-045 drainReq drop -> RUN and grants resume.
